// File: rtl/bsg_fsb_murn_gateway_multi.sv
// rtl/bsg_fsb_murn_gateway_multi.sv - multi-node FSB gateway with control decode and output buffer
module bsg_fsb_murn_gateway_multi #(
    parameter int width_p     = 80,
    parameter int id_width_p  = 4,
    parameter int id_base_p   = 0,
    parameter int num_nodes_p = 4,
    parameter int fifo_els_p  = 2,
    localparam int NODE_W     = (num_nodes_p > 1) ? $clog2(num_nodes_p) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [width_p-1:0]     data_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [width_p-1:0]     data_o,
    output logic [NODE_W-1:0]      node_o,
    input  logic                   ready_i,
    output logic [num_nodes_p-1:0] node_en_r_o,
    output logic [num_nodes_p-1:0] node_reset_r_o,
    output logic [15:0]            drop_count_r_o
);

    localparam int PTR_W = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int CNT_W = $clog2(fifo_els_p + 1);

    logic [id_width_p-1:0] w_id;
    logic [id_width_p-1:0] w_k;
    logic [NODE_W-1:0]     w_kidx;
    logic                  w_sw;
    logic [1:0]            w_op;
    logic                  w_in_range;
    logic                  w_en_k;
    logic                  w_is_ctrl;
    logic                  w_is_data;
    logic                  w_is_drop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_enq;
    logic                  w_deq;

    logic [num_nodes_p-1:0] r_node_en;
    logic [num_nodes_p-1:0] r_node_reset;
    logic [15:0]            r_drop_count;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [width_p-1:0]     r_mem_data [fifo_els_p];
    logic [NODE_W-1:0]      r_mem_node [fifo_els_p];

    // Header decode; the node offset wraps modulo the id field, so ids below base land out of range.
    always_comb begin
        w_id       = data_i[width_p-1 -: id_width_p];
        w_sw       = data_i[width_p-id_width_p-1];
        w_op       = data_i[1:0];
        w_k        = w_id - id_width_p'(id_base_p);
        w_kidx     = w_k[NODE_W-1:0];
        w_in_range = ({1'b0, w_k} < (id_width_p+1)'(num_nodes_p));
        w_en_k     = w_in_range & r_node_en[w_kidx];
    end

    // Packet classification and handshake; full comes from the registered count only.
    always_comb begin
        w_full    = (r_count == CNT_W'(fifo_els_p));
        w_empty   = (r_count == '0);
        w_is_ctrl = v_i & w_sw & w_in_range;
        w_is_data = v_i & ~w_sw & w_en_k;
        w_is_drop = v_i & ~w_is_ctrl & ~w_is_data;
        ready_o   = v_i & (w_is_data ? ~w_full : 1'b1);
        w_enq     = w_is_data & ~w_full;
        w_deq     = ~w_empty & ready_i;
    end

    // Per-node enable/reset registers written by accepted control packets.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_node_en    <= '0;
            r_node_reset <= '1;
        end else if (w_is_ctrl) begin
            case (w_op)
                2'd0:    r_node_en[w_kidx]    <= 1'b0;
                2'd1:    r_node_en[w_kidx]    <= 1'b1;
                2'd2:    r_node_reset[w_kidx] <= 1'b1;
                default: r_node_reset[w_kidx] <= 1'b0;
            endcase
        end
    end

    // Saturating counter of dropped packets.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_drop_count <= '0;
        end else if (w_is_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    // Circular buffer pointers and occupancy; pointers wrap at the depth, not a power of two.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(fifo_els_p-1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(fifo_els_p-1)) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Buffer storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem_data[r_wr_ptr] <= data_i;
            r_mem_node[r_wr_ptr] <= w_kidx;
        end
    end

    // Head of buffer drives the output stream.
    always_comb begin
        v_o            = ~w_empty;
        data_o         = r_mem_data[r_rd_ptr];
        node_o         = r_mem_node[r_rd_ptr];
        node_en_r_o    = r_node_en;
        node_reset_r_o = r_node_reset;
        drop_count_r_o = r_drop_count;
    end

endmodule

// File: tb/tb_bsg_fsb_murn_gateway_multi.sv
// tb/tb_bsg_fsb_murn_gateway_multi.sv - directed self-checking bench for the multi-node gateway
module tb_bsg_fsb_murn_gateway_multi;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        v_i;
    logic [79:0] data_i;
    logic        ready_o;
    logic        v_o;
    logic [79:0] data_o;
    logic [1:0]  node_o;
    logic        ready_i;
    logic [3:0]  node_en_r_o;
    logic [3:0]  node_reset_r_o;
    logic [15:0] drop_count_r_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [79:0] pa, pb, pc, pe, pf;

    bsg_fsb_murn_gateway_multi dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .v_i            (v_i),
        .data_i         (data_i),
        .ready_o        (ready_o),
        .v_o            (v_o),
        .data_o         (data_o),
        .node_o         (node_o),
        .ready_i        (ready_i),
        .node_en_r_o    (node_en_r_o),
        .node_reset_r_o (node_reset_r_o),
        .drop_count_r_o (drop_count_r_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [79:0] pkt(input logic [3:0] id, input logic sw,
                                        input logic [72:0] pay, input logic [1:0] op);
        return {id, sw, pay, op};
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a packet at the falling edge, check ready_o, let one rising edge pass.
    task automatic send(input logic [79:0] p, input logic exp_rdy, input string tag);
        v_i    = 1'b1;
        data_i = p;
        #1;
        check(tag, 80'(ready_o), 80'(exp_rdy));
        @(negedge clk_i);
        v_i = 1'b0;
    endtask

    initial begin
        pa = pkt(4'd2, 1'b0, 73'h1_2345_6789_abcd_ef01, 2'd0);
        pb = pkt(4'd2, 1'b0, 73'h0_dead_beef_0000_1111, 2'd1);
        pc = pkt(4'd2, 1'b0, 73'h1_cafe_f00d_2222_3333, 2'd2);
        pe = pkt(4'd1, 1'b0, 73'h0_0101_0202_0303_0404, 2'd3);
        pf = pkt(4'd1, 1'b0, 73'h1_a5a5_5a5a_a5a5_5a5a, 2'd1);

        reset_n_i = 1'b0;
        v_i       = 1'b0;
        data_i    = '0;
        ready_i   = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_en",   80'(node_en_r_o),    80'h0);
        check("rst_rst",  80'(node_reset_r_o), 80'hF);
        check("rst_vo",   80'(v_o),            80'h0);
        check("rst_drop", 80'(drop_count_r_o), 80'h0);
        reset_n_i = 1'b1;
        @(negedge clk_i);

        // 1: data to disabled node is dropped
        send(pkt(4'd1, 1'b0, 73'h55, 2'd0), 1'b1, "t1_rdy");
        check("t1_drop", 80'(drop_count_r_o), 80'd1);
        check("t1_vo",   80'(v_o),            80'h0);

        // 2: enable node 2, release its reset, pass one data packet
        send(pkt(4'd2, 1'b1, 73'h0, 2'd1), 1'b1, "t2_ctrl_en_rdy");
        check("t2_en", 80'(node_en_r_o), 80'h4);
        send(pkt(4'd2, 1'b1, 73'h0, 2'd3), 1'b1, "t2_ctrl_rst_rdy");
        check("t2_rst", 80'(node_reset_r_o), 80'hB);
        check("t2_en_kept", 80'(node_en_r_o), 80'h4);
        send(pa, 1'b1, "t2_data_rdy");
        check("t2_vo",   80'(v_o),    80'h1);
        check("t2_node", 80'(node_o), 80'h2);
        check("t2_data", data_o,      pa);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        check("t2_drained", 80'(v_o), 80'h0);

        // 3: fill the 2-deep buffer, third packet stalls until one drains
        send(pa, 1'b1, "t3_a_rdy");
        send(pb, 1'b1, "t3_b_rdy");
        v_i    = 1'b1;
        data_i = pc;
        #1;
        check("t3_c_blocked", 80'(ready_o), 80'h0);
        check("t3_head_a", data_o, pa);
        @(negedge clk_i);
        check("t3_still_blocked", 80'(ready_o), 80'h0);
        ready_i = 1'b1;
        #1;
        check("t3_blocked_on_deq", 80'(ready_o), 80'h0);
        @(negedge clk_i);
        ready_i = 1'b0;
        check("t3_head_b", data_o, pb);
        check("t3_c_rdy",  80'(ready_o), 80'h1);
        @(negedge clk_i);
        v_i = 1'b0;
        check("t3_head_b_hold", data_o, pb);
        ready_i = 1'b1;
        @(negedge clk_i);
        check("t3_head_c", data_o, pc);
        check("t3_vo_c",   80'(v_o), 80'h1);
        @(negedge clk_i);
        ready_i = 1'b0;
        check("t3_empty", 80'(v_o), 80'h0);
        check("t3_drop",  80'(drop_count_r_o), 80'd1);

        // 4: out-of-range id is dropped whether data or control
        send(pkt(4'd7, 1'b0, 73'h77, 2'd1), 1'b1, "t4_data_rdy");
        check("t4_drop_data", 80'(drop_count_r_o), 80'd2);
        check("t4_vo", 80'(v_o), 80'h0);
        send(pkt(4'd7, 1'b1, 73'h0, 2'd1), 1'b1, "t4_ctrl_rdy");
        check("t4_en",  80'(node_en_r_o),    80'h4);
        check("t4_drop_ctrl", 80'(drop_count_r_o), 80'd3);

        // 5: buffered packets survive disabling their node
        send(pkt(4'd1, 1'b1, 73'h0, 2'd1), 1'b1, "t5_en1_rdy");
        check("t5_en", 80'(node_en_r_o), 80'h6);
        send(pe, 1'b1, "t5_e_rdy");
        send(pf, 1'b1, "t5_f_rdy");
        send(pkt(4'd1, 1'b1, 73'h0, 2'd0), 1'b1, "t5_dis_rdy_full");
        check("t5_en_dis", 80'(node_en_r_o), 80'h4);
        check("t5_head_e", data_o, pe);
        check("t5_node_e", 80'(node_o), 80'h1);
        ready_i = 1'b1;
        @(negedge clk_i);
        check("t5_head_f", data_o, pf);
        check("t5_node_f", 80'(node_o), 80'h1);
        @(negedge clk_i);
        ready_i = 1'b0;
        check("t5_empty", 80'(v_o), 80'h0);
        send(pkt(4'd1, 1'b0, 73'h9, 2'd0), 1'b1, "t5_late_rdy");
        check("t5_late_drop", 80'(drop_count_r_o), 80'd4);
        check("t5_late_vo",   80'(v_o), 80'h0);

        // 6: asynchronous reset with a full buffer, no clock edge
        send(pa, 1'b1, "t6_a_rdy");
        send(pb, 1'b1, "t6_b_rdy");
        check("t6_full_vo", 80'(v_o), 80'h1);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("t6_vo",   80'(v_o),            80'h0);
        check("t6_en",   80'(node_en_r_o),    80'h0);
        check("t6_rst",  80'(node_reset_r_o), 80'hF);
        check("t6_drop", 80'(drop_count_r_o), 80'h0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check("t6_after_vo", 80'(v_o), 80'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
